// File: rtl/vertex_fetch.sv
// vertex_fetch: reads an object's vertices (four 32-bit words each) from a
// synchronous BRAM and presents them one at a time to the transformation stage
// over a valid/ready handshake.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   start_in              one-cycle pulse, begins an object (only honoured in IDLE)
//   base_addr_in          word address of vertex 0, word 0 (sampled with start_in)
//   vertex_count_in       number of vertices (sampled with start_in)
//   mem_addr_out          BRAM read address
//   mem_data_in           BRAM read data, BRAM_LATENCY cycles after the address
//   ready_in              downstream accepts a vertex
//   valid_out             pos_out/obj_done_out hold a vertex
//   pos_out[0:3]          vertex words, passed through bit-exact
//   obj_done_out          presented vertex is the object's last
//   busy_out              high whenever not IDLE
//   done_out              one-cycle pulse once the object is fully delivered
module vertex_fetch #(
   parameter int ADDR_WIDTH   = 12,
   parameter int BRAM_LATENCY = 2,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [ADDR_WIDTH-1:0]  base_addr_in,
   input  logic [COUNT_WIDTH-1:0] vertex_count_in,
   output logic [ADDR_WIDTH-1:0]  mem_addr_out,
   input  logic [31:0]            mem_data_in,
   input  logic                   ready_in,
   output logic                   valid_out,
   output logic [31:0]            pos_out [4],
   output logic                   obj_done_out,
   output logic                   busy_out,
   output logic                   done_out
);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

   state_t                 state_r, state_nxt;
   logic [COUNT_WIDTH-1:0] cnt_r;
   logic [COUNT_WIDTH-1:0] idx_r;
   logic                   issuing_r;      // mem_addr_out currently carries a live read
   logic [1:0]             word_r;         // word index of the read on mem_addr_out
   // Tags travelling alongside the BRAM read latency: slot BRAM_LATENCY-1 marks
   // the cycle in which mem_data_in holds the data for that word.
   logic                   pipe_v [BRAM_LATENCY];
   logic [1:0]             pipe_k [BRAM_LATENCY];

   logic start_go, start_zero, next_vtx, last_xfer, cap_last, is_last;

   // Next-state logic and one-cycle control strobes.
   always_comb begin
      state_nxt  = state_r;
      start_go   = 1'b0;
      start_zero = 1'b0;
      next_vtx   = 1'b0;
      last_xfer  = 1'b0;
      is_last    = (idx_r == (cnt_r - COUNT_WIDTH'(1)));
      cap_last   = pipe_v[BRAM_LATENCY-1] && (pipe_k[BRAM_LATENCY-1] == 2'd3);
      case (state_r)
         IDLE: begin
            if (start_in) begin
               if (vertex_count_in != COUNT_WIDTH'(0)) begin
                  start_go  = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  start_zero = 1'b1;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         FETCH: begin
            if (cap_last) begin
               state_nxt = PRESENT;
            end else begin
               state_nxt = FETCH;
            end
         end
         PRESENT: begin
            if (ready_in) begin
               if (is_last) begin
                  last_xfer = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  next_vtx  = 1'b1;
                  state_nxt = FETCH;
               end
            end else begin
               state_nxt = PRESENT;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Address issue, read-latency tag pipeline, data capture and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_r        <= '0;
         idx_r        <= '0;
         issuing_r    <= 1'b0;
         word_r       <= 2'd0;
         mem_addr_out <= '0;
         valid_out    <= 1'b0;
         obj_done_out <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         for (int i = 0; i < 4; i++) pos_out[i] <= 32'd0;
         for (int i = 0; i < BRAM_LATENCY; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_k[i] <= 2'd0;
         end
      end else begin
         busy_out <= (state_nxt != IDLE);
         done_out <= start_zero | last_xfer;

         pipe_v[0] <= issuing_r;
         pipe_k[0] <= word_r;
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_k[i] <= pipe_k[i-1];
         end

         // Vertices are contiguous, so the next vertex's word 0 is simply the
         // address after the previous word 3; the base only needs loading once.
         if (start_go) begin
            mem_addr_out <= base_addr_in;
            cnt_r        <= vertex_count_in;
            idx_r        <= '0;
            issuing_r    <= 1'b1;
            word_r       <= 2'd0;
         end else if (next_vtx) begin
            mem_addr_out <= mem_addr_out + ADDR_WIDTH'(1);
            idx_r        <= idx_r + COUNT_WIDTH'(1);
            issuing_r    <= 1'b1;
            word_r       <= 2'd0;
         end else if (issuing_r) begin
            if (word_r == 2'd3) begin
               issuing_r <= 1'b0;
            end else begin
               mem_addr_out <= mem_addr_out + ADDR_WIDTH'(1);
               word_r       <= word_r + 2'd1;
            end
         end

         if (pipe_v[BRAM_LATENCY-1]) begin
            pos_out[pipe_k[BRAM_LATENCY-1]] <= mem_data_in;
         end

         if ((state_r == FETCH) && cap_last) begin
            valid_out    <= 1'b1;
            obj_done_out <= is_last;
         end else if (next_vtx || last_xfer) begin
            valid_out    <= 1'b0;
            obj_done_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vertex_fetch.sv
// Self-checking bench for vertex_fetch: a BRAM model with 2-cycle read latency,
// and a reference model that predicts the vertex stream, addresses, handshake
// timing and done/busy behaviour from the block's documented cycle rules.
module tb_vertex_fetch;
   localparam int AW = 12;
   localparam int L  = 2;
   localparam int CW = 16;

   logic          clk_in = 1'b0;
   logic          rst_in, start_in, ready_in;
   logic [AW-1:0] base_addr_in, mem_addr_out;
   logic [CW-1:0] vertex_count_in;
   logic [31:0]   mem_data_in;
   logic          valid_out, obj_done_out, busy_out, done_out;
   logic [31:0]   pos_out [4];

   logic [31:0]   mem [1<<AW];
   logic [31:0]   rd_pipe [L];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_in = ~clk_in;

   vertex_fetch #(.ADDR_WIDTH(AW), .BRAM_LATENCY(L), .COUNT_WIDTH(CW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
      .base_addr_in(base_addr_in), .vertex_count_in(vertex_count_in),
      .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
      .ready_in(ready_in), .valid_out(valid_out), .pos_out(pos_out),
      .obj_done_out(obj_done_out), .busy_out(busy_out), .done_out(done_out)
   );

   // Synchronous BRAM with L cycles of read latency.
   always @(posedge clk_in) begin
      rd_pipe[0] <= mem[mem_addr_out];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data_in = rd_pipe[L-1];

   // Runs one object and checks every cycle against the model.
   // rmode: 0 ready always high, 1 random ready, 2 ready low in cycles 7..11.
   task automatic run_object(input logic [AW-1:0] base, input int cnt,
                             input int rmode, input bit poke_start);
      int c, beat, next_valid, issue_start, last_c;
      bit finished, exp_valid, exp_done;
      logic [AW-1:0] a;
      logic [31:0] e;
      c = 0; beat = 0; next_valid = 7; issue_start = 1; last_c = 0;
      finished = (cnt == 0);
      @(negedge clk_in);
      base_addr_in = base; vertex_count_in = CW'(cnt); start_in = 1'b1; ready_in = 1'b0;
      while (!(finished && c > last_c + 2)) begin
         @(negedge clk_in);
         c++;
         start_in = poke_start && (c == 2);
         if (poke_start && c == 2) begin
            base_addr_in = base + 12'd40;
            vertex_count_in = 16'd9;
         end
         case (rmode)
            0: ready_in = 1'b1;
            1: ready_in = 1'($urandom_range(0, 1));
            default: ready_in = !(c >= 7 && c <= 11);
         endcase
         if (c > 2000) begin
            vectors++; miscompares++;
            $display("FAIL timeout: object base=%0d cnt=%0d beats=%0d of %0d", base, cnt, beat, cnt);
            break;
         end
         exp_valid = !finished && (beat < cnt) && (c >= next_valid);
         exp_done  = finished && (c == last_c + 1);
         vectors++;
         if (valid_out !== exp_valid) begin
            miscompares++;
            $display("FAIL valid cyc=%0d: got %b want %b", c, valid_out, exp_valid);
         end
         vectors++;
         if (busy_out !== !finished) begin
            miscompares++;
            $display("FAIL busy cyc=%0d: got %b want %b", c, busy_out, !finished);
         end
         vectors++;
         if (done_out !== exp_done) begin
            miscompares++;
            $display("FAIL done cyc=%0d: got %b want %b", c, done_out, exp_done);
         end
         vectors++;
         if (obj_done_out !== (exp_valid && (beat == cnt - 1))) begin
            miscompares++;
            $display("FAIL obj_done cyc=%0d: got %b want %b", c, obj_done_out,
                     exp_valid && (beat == cnt - 1));
         end
         if (exp_valid) begin
            for (int k = 0; k < 4; k++) begin
               a = base + AW'(4 * beat + k);
               e = mem[a];
               vectors++;
               if (pos_out[k] !== e) begin
                  miscompares++;
                  $display("FAIL pos%0d cyc=%0d beat=%0d: got %h want %h", k, c, beat, pos_out[k], e);
               end
            end
         end
         if (!finished && c >= issue_start && c <= issue_start + 3) begin
            a = base + AW'(4 * beat + (c - issue_start));
            vectors++;
            if (mem_addr_out !== a) begin
               miscompares++;
               $display("FAIL addr cyc=%0d: got %0d want %0d", c, mem_addr_out, a);
            end
         end
         if (exp_valid && ready_in) begin
            beat++;
            next_valid = c + 7;
            issue_start = c + 1;
            if (beat == cnt) begin
               finished = 1'b1;
               last_c = c;
            end
         end
      end
      start_in = 1'b0;
      ready_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
      base_addr_in = '0; vertex_count_in = '0;
      repeat (3) @(negedge clk_in);
      vectors++;
      if ({valid_out, obj_done_out, busy_out, done_out} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset flags: got %b want 0000", {valid_out, obj_done_out, busy_out, done_out});
      end
      vectors++;
      if (mem_addr_out !== 12'd0) begin
         miscompares++;
         $display("FAIL reset addr: got %0d want 0", mem_addr_out);
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (pos_out[k] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset pos%0d: got %h want 0", k, pos_out[k]);
         end
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_single();
      mem[0] = 32'h3f800000; mem[1] = 32'h40000000;
      mem[2] = 32'h40400000; mem[3] = 32'h3f800000;
      run_object(12'd0, 1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_object(12'd0, 1, 2, 1'b0);
   endtask

   task automatic test_three();
      run_object(12'd8, 3, 0, 1'b0);
   endtask

   task automatic test_zero_and_busy_start();
      run_object(12'd5, 0, 0, 1'b0);
      run_object(12'd200, 2, 0, 1'b1);
   endtask

   task automatic test_wrap();
      run_object(12'hffe, 1, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk_in);
      base_addr_in = 12'd100; vertex_count_in = 16'd2; start_in = 1'b1; ready_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      vectors++;
      if (mem_addr_out !== 12'd102) begin
         miscompares++;
         $display("FAIL rstmid word2 addr: got %0d want 102", mem_addr_out);
      end
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      vectors++;
      if ({valid_out, busy_out, done_out, obj_done_out} !== 4'b0000 || mem_addr_out !== 12'd0
          || pos_out[0] !== 32'd0) begin
         miscompares++;
         $display("FAIL rstmid outputs: flags %b addr %0d pos0 %h want 0000/0/0",
                  {valid_out, busy_out, done_out, obj_done_out}, mem_addr_out, pos_out[0]);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         vectors++;
         if (valid_out !== 1'b0 || done_out !== 1'b0 || busy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid quiet cyc=%0d: valid %b done %b busy %b want 0",
                     i, valid_out, done_out, busy_out);
         end
      end
      run_object(12'd100, 2, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         run_object(AW'($urandom), int'($urandom_range(1, 4)), 1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      test_reset();
      test_single();
      test_backpressure();
      test_three();
      test_zero_and_busy_start();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
